// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register with stall (hold), kill and bubble insertion.
module if_id_reg
  import if_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ILEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            kill,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  input  logic [ILEN-1:0] load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [ILEN-1:0] instr
);

  // Kill beats stall; an unstalled cycle with nothing new becomes a NOP bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= ILEN'(INSTR_NOP);
    end else if (kill) begin
      valid <= 1'b0;
      instr <= ILEN'(INSTR_NOP);
    end else if (!stall) begin
      if (load) begin
        valid <= 1'b1;
        pc    <= load_pc;
        instr <= load_instr;
      end else begin
        valid <= 1'b0;
        instr <= ILEN'(INSTR_NOP);
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC generation, single-outstanding imem handshake,
// one-entry stall buffer and the IF/ID register.
module if_stage
  import if_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_stall,
  input  logic            if_flush,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [ILEN-1:0] if_id_instr,
  output logic            fetch_misalign
);

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] buf_pc;
  logic [ILEN-1:0] buf_instr;
  logic            buf_valid;

  logic            kill;
  logic            deliver;
  logic            release_buf;
  logic            fire;
  logic [XLEN-1:0] pc_inc;

  assign kill        = if_flush | redirect_valid;
  assign deliver     = (state == WAIT) & imem_rvalid & ~kill & ~if_stall;
  assign release_buf = (state == HOLD) & buf_valid & ~kill & ~if_stall;
  assign fire        = imem_req & imem_gnt;
  assign pc_inc      = pc + XLEN'(PC_STEP);
  assign imem_addr   = pc;

  // Request is combinational so a response can be chained into the next fetch.
  always_comb begin
    imem_req = 1'b0;
    unique case (state)
      IDLE:    imem_req = ~kill;
      WAIT:    imem_req = deliver;
      default: imem_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      req_pc         <= '0;
      buf_pc         <= '0;
      buf_instr      <= ILEN'(INSTR_NOP);
      buf_valid      <= 1'b0;
      fetch_misalign <= 1'b0;
    end else begin
      fetch_misalign <= redirect_valid & (|redirect_pc[1:0]);

      if (redirect_valid) begin
        pc <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (fire) begin
        pc <= pc_inc;
      end

      if (fire) begin
        req_pc <= pc;
      end

      unique case (state)
        IDLE: begin
          // A grant under kill was already accepted; its response must be eaten.
          if (imem_gnt) begin
            state <= kill ? DROP : WAIT;
          end
        end
        WAIT: begin
          if (kill) begin
            state <= imem_rvalid ? IDLE : DROP;
          end else if (imem_rvalid) begin
            if (if_stall) begin
              buf_pc    <= req_pc;
              buf_instr <= imem_rdata;
              buf_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              state <= imem_gnt ? WAIT : IDLE;
            end
          end
        end
        HOLD: begin
          if (kill || !if_stall) begin
            buf_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        DROP: begin
          if (imem_rvalid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  if_id_reg #(
    .XLEN(XLEN),
    .ILEN(ILEN)
  ) u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .stall     (if_stall),
    .kill      (kill),
    .load      (deliver | release_buf),
    .load_pc   (release_buf ? buf_pc : req_pc),
    .load_instr(release_buf ? buf_instr : imem_rdata),
    .valid     (if_id_valid),
    .pc        (if_id_pc),
    .instr     (if_id_instr)
  );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios then randomized traffic, checked
// against an in-order instruction-stream model and a simple imem model.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        if_stall;
  logic        if_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        fetch_misalign;

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .if_stall      (if_stall),
    .if_flush      (if_flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_id_valid   (if_id_valid),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .fetch_misalign(fetch_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // stimulus for the next cycle
  logic        s_rst, s_stall, s_flush, s_redir;
  logic [31:0] s_rpc;

  // imem model
  bit          outstanding = 0;
  logic [31:0] out_addr    = '0;
  int          lat_cnt     = 0;
  int          gnt_pct     = 100;
  int          lat_min     = 1;
  int          lat_max     = 1;

  // stream model
  logic [31:0] exp_next   = '0;
  bit          resync     = 0;
  int          deliveries = 0;

  logic        pre_req, last_req, last_gnt, last_rst;
  logic [31:0] pre_addr, last_addr;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, let imem grant, check handshake, then check IF/ID after the edge.
  task automatic step();
    logic        p_kill;
    logic        pv;
    logic [31:0] ppc, pinstr;
    @(negedge clk);
    rst            = s_rst;
    if_stall       = s_stall;
    if_flush       = s_flush;
    redirect_valid = s_redir;
    redirect_pc    = s_rpc;
    imem_rvalid    = outstanding && (lat_cnt == 0) && !s_rst;
    imem_rdata     = imem_rvalid ? mem_f(out_addr) : $urandom;
    imem_gnt       = 1'b0;
    #1;
    pre_req  = imem_req;
    pre_addr = imem_addr;
    imem_gnt = pre_req && !s_rst && (!outstanding || imem_rvalid) &&
               ($urandom_range(99) < gnt_pct);
    #1;
    p_kill = s_flush | s_redir;
    if (!s_rst) begin
      chk32("addr_align", {30'd0, pre_addr[1:0]}, 32'd0);
      if (last_req && !last_gnt && !last_rst && !p_kill) begin
        chk1("req_hold", pre_req, 1'b1);
        chk32("addr_hold", pre_addr, last_addr);
      end
      chk1("one_outstanding", pre_req && outstanding && !imem_rvalid, 1'b0);
    end
    last_req  = pre_req;
    last_gnt  = imem_gnt;
    last_addr = pre_addr;
    last_rst  = s_rst;
    pv     = if_id_valid;
    ppc    = if_id_pc;
    pinstr = if_id_instr;
    @(posedge clk);
    #1;
    if (s_rst) begin
      outstanding = 0;
    end else begin
      if (imem_rvalid) outstanding = 0;
      else if (outstanding && lat_cnt > 0) lat_cnt--;
      if (imem_gnt) begin
        outstanding = 1;
        out_addr    = pre_addr;
        lat_cnt     = int'($urandom_range(lat_max, lat_min)) - 1;
      end
    end
    if (s_rst) begin
      chk1("rst_valid", if_id_valid, 1'b0);
      chk32("rst_pc", if_id_pc, 32'd0);
      chk32("rst_instr", if_id_instr, NOP);
      chk1("rst_misalign", fetch_misalign, 1'b0);
      chk32("rst_addr", imem_addr, 32'd0);
      exp_next = 32'd0;
      resync   = 0;
    end else begin
      chk1("misalign", fetch_misalign, s_redir && (s_rpc[1:0] != 2'b00));
      if (p_kill) begin
        chk1("kill_valid", if_id_valid, 1'b0);
        chk32("kill_instr", if_id_instr, NOP);
        chk32("kill_pc", if_id_pc, ppc);
      end else if (s_stall) begin
        chk1("stall_valid", if_id_valid, pv);
        chk32("stall_pc", if_id_pc, ppc);
        chk32("stall_instr", if_id_instr, pinstr);
      end else if (if_id_valid) begin
        if (!resync) chk32("stream_pc", if_id_pc, exp_next);
        chk32("instr_data", if_id_instr, mem_f(if_id_pc));
        exp_next = if_id_pc + 32'd4;
        resync   = 0;
        deliveries++;
      end else begin
        chk32("bubble_instr", if_id_instr, NOP);
        chk32("bubble_pc", if_id_pc, ppc);
      end
      if (s_redir) begin
        exp_next = {s_rpc[31:2], 2'b00};
        resync   = 0;
      end else if (s_flush) begin
        resync = 1;
      end
    end
  endtask

  task automatic do_reset();
    s_rst = 1'b1; s_stall = 1'b0; s_flush = 1'b0; s_redir = 1'b0; s_rpc = '0;
    step();
    step();
    s_rst = 1'b0;
  endtask

  initial begin
    int          got_n;
    bit          got;
    logic [31:0] wrap_pc [3];
    logic [31:0] r;

    rst = 1'b1; if_stall = 1'b0; if_flush = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    last_req = 1'b0; last_gnt = 1'b0; last_rst = 1'b1; last_addr = '0;

    // 1: streaming fetch after reset, one instruction per cycle
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step();
      chk1("t1_req", pre_req, 1'b1);
      chk32("t1_addr", pre_addr, 32'(4 * k));
      if (k == 0) begin
        chk1("t1_fill", if_id_valid, 1'b0);
      end else begin
        chk1("t1_valid", if_id_valid, 1'b1);
        chk32("t1_pc", if_id_pc, 32'(4 * (k - 1)));
        chk32("t1_instr", if_id_instr, mem_f(32'(4 * (k - 1))));
      end
    end

    // 2: stall while the response for pc 8 returns
    do_reset();
    repeat (3) step();
    s_stall = 1'b1;
    repeat (3) begin
      step();
      chk1("t2_noreq", pre_req, 1'b0);
      chk1("t2_valid", if_id_valid, 1'b1);
      chk32("t2_frozen", if_id_pc, 32'h4);
    end
    s_stall = 1'b0;
    step();
    chk1("t2_rel_noreq", pre_req, 1'b0);
    chk32("t2_rel_pc", if_id_pc, 32'h8);
    chk32("t2_rel_instr", if_id_instr, mem_f(32'h8));
    step();
    chk1("t2_resume_req", pre_req, 1'b1);
    chk32("t2_resume_addr", pre_addr, 32'hC);

    // 3: redirect + flush while waiting on a slow response
    do_reset();
    lat_min = 2; lat_max = 2;
    step();
    s_redir = 1'b1; s_flush = 1'b1; s_rpc = 32'h100;
    step();
    chk1("t3_valid", if_id_valid, 1'b0);
    chk32("t3_instr", if_id_instr, NOP);
    s_redir = 1'b0; s_flush = 1'b0;
    step();
    chk1("t3_drop_noreq", pre_req, 1'b0);
    chk1("t3_drop_valid", if_id_valid, 1'b0);
    step();
    chk1("t3_req", pre_req, 1'b1);
    chk32("t3_addr", pre_addr, 32'h100);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (if_id_valid) got = 1;
    end
    chk1("t3_timeout", got, 1'b1);
    chk32("t3_first_pc", if_id_pc, 32'h100);
    lat_min = 1; lat_max = 1;

    // 4: flush and stall together while holding a buffered instruction
    do_reset();
    step();
    s_stall = 1'b1;
    step();
    s_flush = 1'b1;
    step();
    chk1("t4_valid", if_id_valid, 1'b0);
    chk32("t4_instr", if_id_instr, NOP);
    s_flush = 1'b0; s_stall = 1'b0;
    step();
    chk1("t4_req", pre_req, 1'b1);
    chk32("t4_addr", pre_addr, 32'h4);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (if_id_valid) got = 1;
    end
    chk1("t4_timeout", got, 1'b1);
    chk32("t4_first_pc", if_id_pc, 32'h4);

    // 5: misaligned redirect target
    do_reset();
    s_redir = 1'b1; s_rpc = 32'h102;
    step();
    chk1("t5_pulse", fetch_misalign, 1'b1);
    chk32("t5_aligned", imem_addr, 32'h100);
    s_redir = 1'b0;
    step();
    chk1("t5_req", pre_req, 1'b1);
    chk32("t5_addr", pre_addr, 32'h100);
    chk1("t5_pulse_end", fetch_misalign, 1'b0);

    // 6: reset in the middle of a fetch
    do_reset();
    repeat (3) step();
    chk1("t6_pre_valid", if_id_valid, 1'b1);
    s_rst = 1'b1;
    step();
    chk1("t6_valid", if_id_valid, 1'b0);
    chk32("t6_addr", imem_addr, 32'h0);
    s_rst = 1'b0;
    step();
    chk1("t6_req", pre_req, 1'b1);
    chk32("t6_restart", pre_addr, 32'h0);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (if_id_valid) got = 1;
    end
    chk1("t6_timeout", got, 1'b1);
    chk32("t6_first_pc", if_id_pc, 32'h0);

    // 7: PC wraps through the top of the address space
    do_reset();
    wrap_pc[0] = 32'hFFFF_FFF8; wrap_pc[1] = 32'hFFFF_FFFC; wrap_pc[2] = 32'h0;
    s_redir = 1'b1; s_rpc = 32'hFFFF_FFF8;
    step();
    s_redir = 1'b0;
    got_n = 0;
    for (int i = 0; i < 20 && got_n < 3; i++) begin
      step();
      if (if_id_valid) begin
        chk32("t7_wrap", if_id_pc, wrap_pc[got_n]);
        got_n++;
      end
    end
    chk32("t7_timeout", 32'(got_n), 32'd3);

    // randomized traffic
    do_reset();
    gnt_pct = 70; lat_min = 1; lat_max = 3;
    deliveries = 0;
    for (int c = 0; c < 3000; c++) begin
      s_rst   = ($urandom_range(999) < 4);
      s_stall = ($urandom_range(99) < 25);
      s_redir = ($urandom_range(99) < 5);
      s_flush = s_redir && ($urandom_range(1) == 1);
      r = $urandom;
      if ($urandom_range(3) == 0) r = 32'hFFFF_FFF0 | (r & 32'hF);
      s_rpc = r;
      step();
    end
    chk1("liveness", deliveries > 300, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
